sky130_sram_1rw1r_arb: RTL and testbench
========================================

Name: sky130_sram_1rw1r_arb

Overview:
- Two-requester scheduler in front of one sky130 1RW+1R SRAM macro (32x512, byte write mask).
- Maps each cycle's requests onto macro port 0 (RW) and port 1 (R), resolves write/write and read-after-write collisions, and returns read data with fixed 1-cycle latency.
- Sits between the core/DMA fabric and the macro; macro clk0 and clk1 are both tied to clk.

Parameters:
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane mask width (DATA_WIDTH/8).

Ports:
- clk  in  1  clock; also drives macro clk0 and clk1.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit k = requester k).
- req_ready  out  2  request accepted this cycle when valid&ready.
- req_we  in  2  1 = write, 0 = read.
- req_wmask  in  2*NUM_WMASKS  byte mask per requester.
- req_addr  in  2*ADDR_WIDTH  word address per requester.
- req_wdata  in  2*DATA_WIDTH  write data per requester.
- rsp_valid  out  2  read data valid, one cycle.
- rsp_rdata  out  2*DATA_WIDTH  read data per requester.
- csb0, web0  out  1 each  macro port 0 controls, active low.
- wmask0  out  NUM_WMASKS  macro port 0 write mask.
- addr0  out  ADDR_WIDTH  macro port 0 address.
- din0  out  DATA_WIDTH  macro port 0 write data.
- dout0  in  DATA_WIDTH  macro port 0 read data.
- csb1  out  1  macro port 1 chip select, active low.
- addr1  out  ADDR_WIDTH  macro port 1 address.
- dout1  in  DATA_WIDTH  macro port 1 read data.

Behaviour:
- Macro controls are combinational from the current requests; the macro captures them at posedge.
- Reset (rst_n low, asynchronous):
  - csb0 = csb1 = 1, web0 = 1, req_ready = 0, rsp_valid = 0, rr_ptr = 0.
  - Any pending response is dropped.
- Port mapping per cycle:
  - Writes go only to port 0.
  - R0 alone: port 0.
  - R1 alone: port 1.
  - R0 + R1: R0 on port 0, R1 on port 1, both accepted.
  - Wk + R(other): write on port 0, read on port 1.
- Collision stall: Wk + R(other) at the same address -> the read gets ready = 0 and is retried next cycle. The macro write lands at negedge, so the retry sees the new data.
- W0 + W1: the rr_ptr requester is granted, the other stalls. rr_ptr flips only after a contended grant.
- Writes with wmask = 0 are accepted and issued with no storage effect.
- Read latency: accepted at posedge N, rsp_valid[k] = 1 for exactly cycle N+1.
  - rsp_rdata[k] = dout0 or dout1, selected by a registered port-select flop.
  - Responses have no backpressure.
- Writes produce no response.
- Unused port: csb driven 1. addr/din/wmask of an idle port are don't-care and are driven 0.
- Requests may be dropped when ready = 0; the interface is not sticky.

Optional Feature:
- SRAM_ARB_STATS_EN defined: adds outputs stall_cnt (16b) and wr_cnt (16b), both saturating, cleared by reset.
  - stall_cnt increments once per cycle in which any valid request sees ready = 0.
  - wr_cnt increments per issued write.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package sram_arb_pkg:
  - ADDR_WIDTH, DATA_WIDTH and NUM_WMASKS defaults.
  - port_sel_e enum {PORT0, PORT1}.
  - Struct for a decoded request (we, wmask, addr, wdata).
- Sub-module sram_arb_sched: purely combinational port-mapping, collision and rr-grant logic.
- Top module: rr_ptr, response and port-select registers, rdata muxing and optional counters.

Test Plan:
- Reset: hold rst_n = 0 with both requests valid -> csb0 = csb1 = 1, req_ready = 00, rsp_valid = 00. Release -> rr_ptr = 0.
- Write then read: R0 writes 0xDEADBEEF to 0x010 with mask 0xF; next cycle R0 reads 0x010 -> rsp_valid[0] one cycle later, rdata 0xDEADBEEF.
- Dual read: preload 0x001 = 0x11111111 and 0x1FF = 0x22222222; R0 reads 0x001 and R1 reads 0x1FF in the same cycle -> both ready; next cycle rsp_rdata = 0x11111111 / 0x22222222.
- Collision: preload 0x020 = 0; R0 writes 0xA5A5A5A5 (mask 0x3) to 0x020 while R1 reads 0x020 -> R1 stalled one cycle; retry returns 0x0000A5A5.
- Write/write round-robin: both write 0x030 for 3 cycles -> grants alternate R0, R1, R0 with the other ready = 0. Final word equals the last granted requester's data.
- Reset mid-read: assert rst_n low in the cycle after a read is accepted -> rsp_valid stays 0. After release, a new read completes normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the 1RW+1R SRAM arbiter.
// Macro geometry is fixed by the sky130 32x512 instance; struct fields follow these widths.
package sram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic                      we;
        logic [DEF_NUM_WMASKS-1:0] wmask;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_sched.sv
// Combinational scheduler: maps two requests onto macro port 0 (RW) and port 1 (R),
// resolving write/write contention by round-robin and stalling same-address reads behind a write.
module sram_arb_sched
    import sram_arb_pkg::*;
(
    input  logic                      en,
    input  logic [1:0]                req_valid,
    input  sram_req_t                 req [2],
    input  logic                      rr_ptr,
    output logic [1:0]                req_ready,
    output logic [1:0]                rd_acc,
    output port_sel_e                 rd_port [2],
    output logic                      contended,
    output logic                      csb0,
    output logic                      web0,
    output logic [DEF_NUM_WMASKS-1:0] wmask0,
    output logic [DEF_ADDR_WIDTH-1:0] addr0,
    output logic [DEF_DATA_WIDTH-1:0] din0,
    output logic                      csb1,
    output logic [DEF_ADDR_WIDTH-1:0] addr1
);

    logic [1:0] is_wr;
    logic [1:0] is_rd;
    logic       wsel;
    logic       rsel;
    logic       collide;

    assign is_wr     = req_valid & {req[1].we, req[0].we};
    assign is_rd     = req_valid & ~{req[1].we, req[0].we};
    assign contended = en & is_wr[0] & is_wr[1];
    // With a single writer wsel points at it; with two, the round-robin pointer decides.
    assign wsel      = (&is_wr) ? rr_ptr : is_wr[1];
    assign rsel      = ~wsel;
    assign collide   = (req[rsel].addr == req[wsel].addr);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        req_ready  = '0;
        rd_acc     = '0;
        rd_port[0] = PORT0;
        rd_port[1] = PORT0;
        csb0       = 1'b1;
        web0       = 1'b1;
        wmask0     = '0;
        addr0      = '0;
        din0       = '0;
        csb1       = 1'b1;
        addr1      = '0;

        if (en) begin
            if (|is_wr) begin
                req_ready[wsel] = 1'b1;
                csb0            = 1'b0;
                web0            = 1'b0;
                wmask0          = req[wsel].wmask;
                addr0           = req[wsel].addr;
                din0            = req[wsel].wdata;
                // Only the other requester can be reading; it moves to port 1 unless it hits the write address.
                if (is_rd[rsel] && !collide) begin
                    req_ready[rsel] = 1'b1;
                    rd_acc[rsel]    = 1'b1;
                    rd_port[rsel]   = PORT1;
                    csb1            = 1'b0;
                    addr1           = req[rsel].addr;
                end
            end else begin
                if (is_rd[0]) begin
                    req_ready[0] = 1'b1;
                    rd_acc[0]    = 1'b1;
                    rd_port[0]   = PORT0;
                    csb0         = 1'b0;
                    addr0        = req[0].addr;
                end
                if (is_rd[1]) begin
                    req_ready[1] = 1'b1;
                    rd_acc[1]    = 1'b1;
                    rd_port[1]   = PORT1;
                    csb1         = 1'b0;
                    addr1        = req[1].addr;
                end
            end
        end
    end

endmodule

// File: rtl/sky130_sram_1rw1r_arb.sv
// Two-requester front end for a sky130 1RW+1R SRAM macro with 1-cycle read responses.
// Define SRAM_ARB_STATS_EN to add saturating stall_cnt / wr_cnt outputs.
module sky130_sram_1rw1r_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*NUM_WMASKS-1:0] req_wmask,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic                    csb0,
    output logic                    web0,
    output logic [NUM_WMASKS-1:0]   wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0,
    output logic                    csb1,
    output logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   dout1
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             wr_cnt
`endif
);

    sram_req_t req [2];
    logic      rr_ptr;
    logic      contended;
    logic [1:0] rd_acc;
    port_sel_e rd_port    [2];
    port_sel_e port_sel_q [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            req[k].we    = req_we[k];
            req[k].wmask = req_wmask[k*NUM_WMASKS +: NUM_WMASKS];
            req[k].addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            req[k].wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Holding the scheduler disabled while rst_n is low keeps both chip selects high during reset.
    sram_arb_sched u_sched (
        .en        (rst_n),
        .req_valid (req_valid),
        .req       (req),
        .rr_ptr    (rr_ptr),
        .req_ready (req_ready),
        .rd_acc    (rd_acc),
        .rd_port   (rd_port),
        .contended (contended),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .csb1      (csb1),
        .addr1     (addr1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= 1'b0;
            rsp_valid     <= '0;
            port_sel_q[0] <= PORT0;
            port_sel_q[1] <= PORT0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (contended) begin
                rr_ptr <= ~rr_ptr;
            end
            rsp_valid  <= rd_acc;
            port_sel_q <= rd_port;
        end
    end

    // The macro presents read data during the cycle after capture; steer it by the recorded port.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rsp_rdata[k*DATA_WIDTH +: DATA_WIDTH] = (port_sel_q[k] == PORT1) ? dout1 : dout0;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic stall_ev;
    logic wr_ev;

    assign stall_ev = |(req_valid & ~req_ready);
    assign wr_ev    = ~csb0 & ~web0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            wr_cnt    <= '0;
        end else begin
            if (stall_ev && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (wr_ev && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sky130_sram_1rw1r_arb.sv
// Directed bench for sky130_sram_1rw1r_arb with a behavioural macro and a reference scheduler/memory.
// Honors SRAM_ARB_STATS_EN for the optional counter ports.
module tb_sky130_sram_1rw1r_arb;
    import sram_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NM = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [2*NM-1:0] req_wmask;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata, rsp_rdata;
    logic            csb0, web0, csb1;
    logic [NM-1:0]   wmask0;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   din0, dout0, dout1;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]     stall_cnt, wr_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    sky130_sram_1rw1r_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural macro: controls taken just before the edge, write then read at the falling edge.
    logic [DW-1:0] mac_mem [512];
    logic          l_csb0 = 1'b1, l_web0 = 1'b1, l_csb1 = 1'b1;
    logic [NM-1:0] l_wmask0;
    logic [AW-1:0] l_addr0, l_addr1;
    logic [DW-1:0] l_din0;

    initial begin
        for (int i = 0; i < 512; i++) mac_mem[i] = '0;
        dout0 = '0;
        dout1 = '0;
        forever begin
            @(negedge clk);
            if (!l_csb0 && !l_web0) begin
                for (int b = 0; b < NM; b++)
                    if (l_wmask0[b]) mac_mem[l_addr0][8*b +: 8] = l_din0[8*b +: 8];
            end
            if (!l_csb0 && l_web0) dout0 = mac_mem[l_addr0];
            if (!l_csb1) dout1 = mac_mem[l_addr1];
            #4;
            l_csb0 = csb0; l_web0 = web0; l_wmask0 = wmask0;
            l_addr0 = addr0; l_din0 = din0; l_csb1 = csb1; l_addr1 = addr1;
        end
    end

    // Reference: memory contents, round-robin owner and pending responses.
    logic [DW-1:0] ref_mem [512];
    logic          rr_m;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];
    int            stall_m, wr_m;

    initial for (int i = 0; i < 512; i++) ref_mem[i] = '0;

    function automatic logic [AW-1:0] a_of(int k);
        return req_addr[k*AW +: AW];
    endfunction

    function automatic void model_grant(output logic [1:0] rdy, output logic wr,
                                        output int ws, output logic p1);
        int nw;
        int o;
        rdy = '0; wr = 1'b0; ws = 0; p1 = 1'b0; nw = 0;
        if (rst_n !== 1'b1) return;
        for (int k = 0; k < 2; k++)
            if (req_valid[k] && req_we[k]) begin nw++; ws = k; end
        if (nw == 2) begin
            ws = int'(rr_m); wr = 1'b1; rdy[ws] = 1'b1;
        end else if (nw == 1) begin
            wr = 1'b1; rdy[ws] = 1'b1; o = 1 - ws;
            if (req_valid[o] && (a_of(o) != a_of(ws))) begin rdy[o] = 1'b1; p1 = 1'b1; end
        end else begin
            rdy = req_valid; p1 = req_valid[1];
        end
    endfunction

    always @(negedge rst_n) begin
        exp_rv = '0; rr_m = 1'b0; stall_m = 0; wr_m = 0;
    end

    always @(posedge clk) begin
        logic [1:0] rdy; logic wr; int ws; logic p1;
        logic [1:0] nrv;
        if (rst_n !== 1'b1) begin
            exp_rv = '0; rr_m = 1'b0; stall_m = 0; wr_m = 0;
        end else begin
            model_grant(rdy, wr, ws, p1);
            nrv = '0;
            for (int k = 0; k < 2; k++)
                if (rdy[k] && !req_we[k]) begin nrv[k] = 1'b1; exp_rd[k] = ref_mem[a_of(k)]; end
            if (wr) begin
                for (int b = 0; b < NM; b++)
                    if (req_wmask[ws*NM + b]) ref_mem[a_of(ws)][8*b +: 8] = req_wdata[ws*DW + 8*b +: 8];
                wr_m++;
            end
            if (|(req_valid & ~rdy)) stall_m++;
            if (req_valid[0] && req_we[0] && req_valid[1] && req_we[1]) rr_m = ~rr_m;
            exp_rv = nrv;
        end
    end

    // Per-cycle comparison against the reference, late in the cycle.
    initial begin
        logic [1:0] rdy; logic wr; int ws; logic p1;
        forever begin
            @(negedge clk);
            #2;
            model_grant(rdy, wr, ws, p1);
            check("req_ready", 64'(req_ready), 64'(rdy));
            check("csb0", 64'(csb0), 64'(!(wr || rdy[0])));
            check("web0", 64'(web0), 64'(!wr));
            check("csb1", 64'(csb1), 64'(!p1));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            for (int k = 0; k < 2; k++)
                if (exp_rv[k]) check($sformatf("rsp_rdata%0d", k), 64'(rsp_rdata[k*DW +: DW]), 64'(exp_rd[k]));
`ifdef SRAM_ARB_STATS_EN
            check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            check("wr_cnt", 64'(wr_cnt), 64'(wr_m));
`endif
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [3:0] m0, input logic [3:0] m1,
                         input logic [8:0] a0, input logic [8:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v; req_we = we; req_wmask = {m1, m0}; req_addr = {a1, a0}; req_wdata = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 4'h0, 4'h0, 9'h000, 9'h000, 32'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #3;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 4'h0, 4'h0, 9'h001, 9'h002, 32'h0, 32'h0);
        repeat (3) next();
        smp();
        check("lit_rst_csb0", 64'(csb0), 64'd1);
        check("lit_rst_csb1", 64'(csb1), 64'd1);
        check("lit_rst_ready", 64'(req_ready), 64'd0);
        check("lit_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        next(); idle(); rst_n = 1'b1;

        // Write then read back through port 0.
        next(); drive(2'b01, 2'b01, 4'hF, 4'h0, 9'h010, 9'h000, 32'hDEADBEEF, 32'h0);
        smp(); check("lit_wr_ready", 64'(req_ready), 64'h1);
        next(); drive(2'b01, 2'b00, 4'h0, 4'h0, 9'h010, 9'h000, 32'h0, 32'h0);
        next(); idle(); smp();
        check("lit_rd_valid", 64'(rsp_valid), 64'h1);
        check("lit_rd_data", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);

        // Zero-mask write is accepted but leaves storage untouched.
        next(); drive(2'b01, 2'b01, 4'h0, 4'h0, 9'h010, 9'h000, 32'hFFFFFFFF, 32'h0);
        smp(); check("lit_m0_ready", 64'(req_ready), 64'h1);
        next(); drive(2'b10, 2'b00, 4'h0, 4'h0, 9'h000, 9'h010, 32'h0, 32'h0);
        next(); idle(); smp();
        check("lit_m0_valid", 64'(rsp_valid), 64'h2);
        check("lit_m0_data", 64'(rsp_rdata[63:32]), 64'hDEADBEEF);

        // Dual read on both ports.
        next(); drive(2'b01, 2'b01, 4'hF, 4'h0, 9'h001, 9'h000, 32'h11111111, 32'h0);
        next(); drive(2'b10, 2'b10, 4'h0, 4'hF, 9'h000, 9'h1FF, 32'h0, 32'h22222222);
        next(); drive(2'b11, 2'b00, 4'h0, 4'h0, 9'h001, 9'h1FF, 32'h0, 32'h0);
        smp(); check("lit_dual_ready", 64'(req_ready), 64'h3);
        next(); idle(); smp();
        check("lit_dual_valid", 64'(rsp_valid), 64'h3);
        check("lit_dual_data0", 64'(rsp_rdata[31:0]), 64'h11111111);
        check("lit_dual_data1", 64'(rsp_rdata[63:32]), 64'h22222222);

        // Read-after-write collision: R1 stalls once, retry sees the masked write.
        next(); drive(2'b01, 2'b01, 4'hF, 4'h0, 9'h020, 9'h000, 32'h0, 32'h0);
        next(); drive(2'b11, 2'b01, 4'h3, 4'h0, 9'h020, 9'h020, 32'hA5A5A5A5, 32'h0);
        smp(); check("lit_col_ready", 64'(req_ready), 64'h1);
        next(); drive(2'b10, 2'b00, 4'h0, 4'h0, 9'h000, 9'h020, 32'h0, 32'h0);
        smp();
        check("lit_retry_ready", 64'(req_ready), 64'h2);
        check("lit_col_no_rsp", 64'(rsp_valid), 64'h0);
        next(); idle(); smp();
        check("lit_retry_valid", 64'(rsp_valid), 64'h2);
        check("lit_retry_data", 64'(rsp_rdata[63:32]), 64'h0000A5A5);

        // Write/write contention alternates R0, R1, R0.
        for (int i = 0; i < 3; i++) begin
            next();
            drive(2'b11, 2'b11, 4'hF, 4'hF, 9'h030, 9'h030, 32'hC0000000 + 32'(i), 32'hD0000000 + 32'(i));
            smp();
            check($sformatf("lit_ww_ready%0d", i), 64'(req_ready), (i == 1) ? 64'h2 : 64'h1);
        end
        next(); drive(2'b10, 2'b00, 4'h0, 4'h0, 9'h000, 9'h030, 32'h0, 32'h0);
        next(); idle(); smp();
        check("lit_ww_final", 64'(rsp_rdata[63:32]), 64'hC0000002);

        // Reset in the cycle after an accepted read drops the response.
        next(); drive(2'b01, 2'b00, 4'h0, 4'h0, 9'h010, 9'h000, 32'h0, 32'h0);
        next(); idle(); rst_n = 1'b0;
        smp();
        check("lit_rstmid_valid", 64'(rsp_valid), 64'h0);
        check("lit_rstmid_csb0", 64'(csb0), 64'd1);
        next(); next(); rst_n = 1'b1;
        next(); drive(2'b01, 2'b00, 4'h0, 4'h0, 9'h010, 9'h000, 32'h0, 32'h0);
        next(); idle(); smp();
        check("lit_post_valid", 64'(rsp_valid), 64'h1);
        check("lit_post_data", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);

        // rr pointer returned to requester 0 by reset.
        next(); drive(2'b11, 2'b11, 4'hF, 4'hF, 9'h040, 9'h040, 32'h1, 32'h2);
        smp(); check("lit_rr_after_rst", 64'(req_ready), 64'h1);
        next(); idle();
        next();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
